// File: rtl/sync_fifo_wr_arb.sv
// Round-robin write arbiter sharing one sync_fifo write port among NUM_REQ producers.
// Define SYNC_FIFO_WR_ARB_STATS_EN to add the saturating stall_cnt output.
module sync_fifo_wr_arb #(
  parameter int NUM_REQ     = 4,
  parameter int FIFO_DWIDTH = 64,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*FIFO_DWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           fifo_wr_en,
  output logic [FIFO_DWIDTH-1:0]         fifo_wdata,
  input  logic [$clog2(FIFO_DEPTH):0]    fifo_numel,
  input  logic                           fifo_full
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]                    stall_cnt
`endif
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;

  logic [PW-1:0]          ptr;
  logic [PW-1:0]          sel;
  logic                   hit;
  logic                   room;
  logic [NUM_REQ-1:0]     elig;
  logic [NW:0]            occ;
  logic [FIFO_DWIDTH-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign data_arr[g] =
      req_data[g*FIFO_DWIDTH +: FIFO_DWIDTH];
  end

  // A word granted this cycle is still on req; mask it to avoid a double write.
  assign elig = req & ~gnt;

  // Counts the write committing now; concurrent reads are ignored.
  assign occ  = {1'b0, fifo_numel} +
                {{NW{1'b0}}, fifo_wr_en};
  assign room = occ < (NW+1)'(FIFO_DEPTH);

  always_comb begin
    int            idx;
    logic [PW-1:0] sidx;
    hit  = 1'b0;
    sel  = '0;
    idx  = 0;
    sidx = '0;
    // Descending scan: the smallest offset from ptr wins.
    for (int o = NUM_REQ - 1; o >= 0; o--) begin
      idx = int'(ptr) + o;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      sidx = PW'(idx);
      if (elig[sidx]) begin
        hit = 1'b1;
        sel = sidx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= '0;
      fifo_wr_en <= 1'b0;
      fifo_wdata <= '0;
      ptr        <= '0;
    end else if (hit && room) begin
      gnt        <= '0;
      gnt[sel]   <= 1'b1;
      fifo_wr_en <= 1'b1;
      fifo_wdata <= data_arr[sel];
      ptr        <= (sel == PW'(NUM_REQ - 1)) ?
                    '0 : sel + 1'b1;
    end else begin
      gnt        <= '0;
      fifo_wr_en <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (|elig && !room &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  a_no_wr_full: assert property (
    @(posedge clk) disable iff (rst)
    !(fifo_wr_en && fifo_full));

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Randomized scoreboard bench for sync_fifo_wr_arb with a queue-based FIFO stand-in.
// Build with SYNC_FIFO_WR_ARB_STATS_EN to also check stall_cnt.
module tb_sync_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int D  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    gnt;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wdata;
  logic [4:0]      fifo_numel = '0;
  logic            fifo_full = 1'b0;
  logic            rd = 1'b0;
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  logic [15:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  sync_fifo_wr_arb #(
    .NUM_REQ(N), .FIFO_DWIDTH(DW), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wdata(fifo_wdata),
    .fifo_numel(fifo_numel),
    .fifo_full(fifo_full)
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    int          cyc;
    int          idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            wlog[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] dq[N][$];
  logic [DW-1:0] mq[N][$];

  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  int            mptr = 0;
  bit            mlast[N];
  bit            mpend = 0;
  int            lastk = 0;
  logic [DW-1:0] lastw = '0;
  int            mstall = 0;

  exp_t          mon_e;
  int            mon_k;

  // FIFO stand-in
  always @(posedge clk) begin
    cyc++;
    if (rd) void'(fq.pop_front());
    if (fifo_wr_en) begin
      checks++;
      if (fq.size() >= D) begin
        failures++;
        $display("FAIL fifo_overflow size=%0d max=%0d", fq.size(), D);
      end else begin
        fq.push_back(fifo_wdata);
      end
    end
    fifo_numel <= 5'(fq.size());
    fifo_full  <= (fq.size() == D);
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_wr_en) begin
        mon_k = -1;
        for (int i = 0; i < N; i++) if (gnt[i]) mon_k = i;
        checks++;
        if (!$onehot(gnt)) begin
          failures++;
          $display("FAIL gnt_onehot gnt=%b required one-hot", gnt);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write cyc=%0d idx=%0d required none", cyc, mon_k);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.idx != mon_k ||
              mon_e.data != fifo_wdata) begin
            failures++;
            $display("FAIL write cyc=%0d idx=%0d data=%h required cyc=%0d idx=%0d data=%h",
                     cyc, mon_k, fifo_wdata, mon_e.cyc, mon_e.idx, mon_e.data);
          end
        end
        wlog.push_back(mon_k);
      end else begin
        checks++;
        if (gnt != '0) begin
          failures++;
          $display("FAIL gnt_without_wr gnt=%b required 0", gnt);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          checks++;
          failures++;
          $display("FAIL missed_write cyc=%0d required idx=%0d at cyc=%0d",
                   cyc, exp_q[0].idx, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
      end
      checks++;
      if (fifo_wr_en && fifo_full) begin
        failures++;
        $display("FAIL wr_while_full wr_en=1 full=1 required not both");
      end
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
      checks++;
      if (stall_cnt != 16'(mstall)) begin
        failures++;
        $display("FAIL stall_cnt act=%0d exp=%0d", stall_cnt, mstall);
      end
`endif
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += dq[i].size();
    return s;
  endfunction

  task automatic add(int i, logic [DW-1:0] w);
    dq[i].push_back(w);
    mq[i].push_back(w);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = (dq[i].size() > 0);
      req_data[i*DW +: DW] = req[i] ? dq[i][0] : '0;
    end
  endtask

  // Reference: round robin from ptr over requesters with a word
  // that were not granted last cycle, if the FIFO has room.
  task automatic model();
    int  k;
    bit  room;
    if (!rst) begin
      k = -1;
      for (int o = 0; o < N; o++) begin
        if (k < 0 && mq[(mptr+o)%N].size() > 0 && !mlast[(mptr+o)%N])
          k = (mptr + o) % N;
      end
      room = (fq.size() + int'(mpend)) < D;
      for (int i = 0; i < N; i++) mlast[i] = 0;
      if (k >= 0 && room) begin
        exp_q.push_back('{cyc + 1, k, mq[k][0]});
        lastw    = mq[k].pop_front();
        lastk    = k;
        mptr     = (k + 1) % N;
        mlast[k] = 1;
        mpend    = 1;
      end else begin
        if (k >= 0 && mstall < 65535) mstall++;
        mpend = 0;
      end
    end
  endtask

  task automatic model_reset();
    if (mpend) mq[lastk].push_front(lastw);
    exp_q.delete();
    mptr   = 0;
    mpend  = 0;
    mstall = 0;
    for (int i = 0; i < N; i++) mlast[i] = 0;
  endtask

  task automatic tick(int n, int rdp);
    repeat (n) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (gnt[i] && dq[i].size() > 0) void'(dq[i].pop_front());
      rd = (fq.size() > 0) && (int'($urandom_range(99)) < rdp);
      drive();
      model();
    end
  endtask

  task automatic drain();
    int g = 0;
    while (g < 300 && (fq.size() > 0 || pending() > 0 || fifo_wr_en)) begin
      tick(1, 100);
      g++;
    end
    chk("drain_left", 64'(fq.size() + pending()), 0);
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int s;
    int wrap_exp[3];
    wrap_exp[0] = 3; wrap_exp[1] = 0; wrap_exp[2] = 3;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_wr_en", 64'(fifo_wr_en), 0);
    chk("rst_wdata", fifo_wdata, 0);
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    chk("rst_stall", 64'(stall_cnt), 0);
`endif
    @(posedge clk); #2; rst = 1'b0;

    // round robin, all four loaded
    for (int r = 0; r < N; r++)
      for (int w = 0; w < 3; w++) add(r, rnd());
    s = wlog.size();
    tick(20, 100);
    chk("rr_writes", 64'(wlog.size() - s), 12);
    for (int j = 0; j < 12; j++)
      if (s + j < wlog.size()) chk("rr_order", 64'(wlog[s+j]), 64'(j % N));
    drain();

    // single requester
    s = wlog.size();
    for (int w = 0; w < 6; w++) add(2, rnd());
    tick(20, 0);
    chk("single_writes", 64'(wlog.size() - s), 6);
    chk("single_numel", 64'(fifo_numel), 6);
    drain();

    // full boundary
    s = wlog.size();
    for (int r = 0; r < N; r++)
      for (int w = 0; w < 5; w++) add(r, rnd());
    tick(40, 0);
    chk("full_writes", 64'(wlog.size() - s), 16);
    chk("full_numel", 64'(fifo_numel), 16);
    chk("full_flag", 64'(fifo_full), 1);
    s = wlog.size();
    tick(3, 100);
    tick(20, 0);
    chk("full_resume_writes", 64'(wlog.size() - s), 3);

    // stall counting with the FIFO full
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    s = int'(stall_cnt);
`endif
    add(0, rnd());
    tick(10, 0);
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    chk("stall_10", 64'(int'(stall_cnt) - s), 10);
`endif
    drain();

    // ptr wrap
    add(2, rnd());
    tick(5, 100);
    s = wlog.size();
    add(3, rnd()); add(3, rnd()); add(0, rnd());
    tick(10, 100);
    chk("wrap_writes", 64'(wlog.size() - s), 3);
    for (int j = 0; j < 3; j++)
      if (s + j < wlog.size()) chk("wrap_order", 64'(wlog[s+j]), 64'(wrap_exp[j]));

    // random traffic
    repeat (400) begin
      if ($urandom_range(2) != 0) begin
        s = int'($urandom_range(N - 1));
        if (dq[s].size() < 4) add(s, rnd());
      end
      tick(1, int'($urandom_range(100)));
    end
    drain();

    // reset while a grant is in flight
    for (int r = 0; r < N; r++) begin
      add(r, rnd()); add(r, rnd());
    end
    tick(2, 100);
    @(posedge clk); #2;
    chk("pre_rst_wr_en", 64'(fifo_wr_en), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 64'(gnt), 0);
    chk("mid_rst_wr_en", 64'(fifo_wr_en), 0);
    chk("mid_rst_wdata", fifo_wdata, 0);
    model_reset();
    tick(2, 0);
    @(posedge clk); #2; rst = 1'b0;
    s = wlog.size();
    tick(20, 100);
    chk("post_rst_writes", 64'(wlog.size() - s), 7);
    if (s < wlog.size()) chk("post_rst_first", 64'(wlog[s]), 0);
    drain();

    tick(3, 100);
    chk("exp_q_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
